// File: rtl/cache_arb_pkg.sv
// Shared types and defaults for the cache/memory arbiter.
package cache_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    // The requester that is not 'id'.
    function automatic logic other_req(input logic id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between I-cache and D-cache requests.
module arb_pick
    import cache_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last,
    output logic winner_c,
    output logic valid_c
);

    // On a tie, fixed mode favours D; rotating mode favours whoever was not served last.
    always_comb begin
        valid_c  = i_req | d_req;
        winner_c = REQ_I;
        if (i_req && d_req) begin
            winner_c = RR_EN ? other_req(last) : REQ_D;
        end else if (d_req) begin
            winner_c = REQ_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the off-chip memory port between I-cache and D-cache block requests.
// Optional CACHE_ARB_ROUND_ROBIN_EN: alternate priority on simultaneous requests.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_winner;
    logic              pick_valid;
    logic              last_q;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    logic last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end
`else
    localparam bit RR_EN = 1'b0;
    assign last_q = REQ_I;
`endif

    arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_req    (i_read),
        .d_req    (d_read | d_write),
        .last     (last_q),
        .winner_c (pick_winner),
        .valid_c  (pick_valid)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    last_d = pick_winner;
`endif
                    if (pick_winner == REQ_D) begin
                        state_d    = GRANT_D;
                        mem_addr_d = d_addr;
                        // A pending write-back goes before a pending read.
                        if (d_write) begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = d_wdata;
                        end else begin
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        state_d    = GRANT_I;
                        mem_addr_d = i_addr;
                        mem_read_d = 1'b1;
                    end
                end
            end
            GRANT_I: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_rdata_d   = mem_rdata;
                    i_ready_d   = 1'b1;
                    state_d     = RELEASE;
                end
            end
            GRANT_D: begin
                if (mem_ready) begin
                    if (mem_read_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    d_ready_d   = 1'b1;
                    state_d     = RELEASE;
                end
            end
            // One dead cycle lets the just-served requester drop its request.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: vector table, memory model and scoreboards.
module tb_cache_mem_arbiter;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;

    cache_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_read    (i_read),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_ready   (i_ready),
        .d_read    (d_read),
        .d_write   (d_write),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ready   (d_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          n_i;
        int          n_dr;
        int          n_dw;
        logic [27:0] i_addr;
        logic [27:0] d_addr;
        logic [127:0] wdata;
        int          lat;
    } vec_t;

    typedef struct {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] wdata;
        bit           first;
    } mem_exp_t;

    typedef struct {
        logic         is_d;
        logic [127:0] rdata;
    } rdy_exp_t;

    mem_exp_t mem_q[$];
    rdy_exp_t rdy_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic logic [127:0] pat(input logic [27:0] a);
        return {32'hDEADBEEF, 4'h0, a, ~{4'h0, a}, 32'h600DF00D};
    endfunction

    // Memory model state
    int          cur_lat   = 1;
    bit          busy      = 1'b0;
    int          cnt       = 0;
    int          ready_cyc = 0;
    int          drive_cyc = 0;
    bit          inject    = 1'b0;
    logic        cur_wr    = 1'b0;
    logic [27:0] cur_addr  = '0;

    task automatic mem_start();
        mem_exp_t e;
        if (mem_q.size() == 0) begin
            fail_now("extra_mem_txn");
        end else begin
            e = mem_q.pop_front();
            chk("mem_write", 128'(mem_write), 128'(e.wr));
            chk("mem_read", 128'(mem_read), 128'(!e.wr));
            chk("mem_addr", 128'(mem_addr), 128'(e.addr));
            if (e.wr) chk("mem_wdata", mem_wdata, e.wdata);
            if (e.first) chk("strobe_after_req", 128'(cyc - drive_cyc), 128'(1));
            else         chk("turnaround", 128'(cyc - ready_cyc), 128'(3));
        end
    endtask

    // Memory: answers each strobe after cur_lat cycles with a one-cycle mem_ready.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ready = 1'b0;
            busy      = 1'b0;
            inject    = 1'b0;
        end else if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (inject) begin
            mem_ready = 1'b1;
            mem_rdata = '1;
            inject    = 1'b0;
        end else if (busy) begin
            chk("strobe_held", 128'({mem_read, mem_write}), cur_wr ? 128'(1) : 128'(2));
            chk("addr_stable", 128'(mem_addr), 128'(cur_addr));
            if (cnt == 0) begin
                mem_ready = 1'b1;
                mem_rdata = pat(mem_addr);
                busy      = 1'b0;
                ready_cyc = cyc;
            end else begin
                cnt--;
            end
        end else if (mem_read || mem_write) begin
            busy     = 1'b1;
            cnt      = cur_lat - 1;
            cur_wr   = mem_write;
            cur_addr = mem_addr;
            mem_start();
        end
    end

    // Reference arbitration state
    bit           m_last_d  = 1'b0;
    logic [127:0] m_d_rdata = '0;
    logic [127:0] m_i_rdata = '0;

    task automatic check_ready(input logic is_d, input logic [127:0] rdata);
        rdy_exp_t e;
        if (rdy_q.size() == 0) begin
            fail_now("extra_ready");
        end else begin
            e = rdy_q.pop_front();
            chk("ready_who", 128'(is_d), 128'(e.is_d));
            chk(is_d ? "d_rdata" : "i_rdata", rdata, e.rdata);
            chk("ready_latency", 128'(cyc - ready_cyc), 128'(1));
        end
    endtask

    task automatic run_vec(input vec_t v);
        int il;
        int drl;
        int dwl;
        int ni;
        int budget;
        bit first;
        bit pick_d;
        logic [27:0] a;
        il = v.n_i; drl = v.n_dr; dwl = v.n_dw; ni = 0; first = 1'b1;
        // Predict grant order and results.
        while (il > 0 || drl > 0 || dwl > 0) begin
            if (il > 0 && (drl > 0 || dwl > 0)) pick_d = RR ? !m_last_d : 1'b1;
            else                                pick_d = (il == 0);
            m_last_d = pick_d;
            if (pick_d) begin
                if (dwl > 0) begin
                    mem_q.push_back('{1'b1, v.d_addr, v.wdata, first});
                    dwl--;
                end else begin
                    mem_q.push_back('{1'b0, v.d_addr, '0, first});
                    m_d_rdata = pat(v.d_addr);
                    drl--;
                end
                rdy_q.push_back('{1'b1, m_d_rdata});
            end else begin
                a = v.i_addr + 28'(ni);
                mem_q.push_back('{1'b0, a, '0, first});
                m_i_rdata = pat(a);
                rdy_q.push_back('{1'b0, m_i_rdata});
                ni++;
                il--;
            end
            first = 1'b0;
        end
        // Drive requesters; each holds its level until its ready is seen.
        il = v.n_i; drl = v.n_dr; dwl = v.n_dw; ni = 0; budget = 0;
        cur_lat = v.lat;
        @(negedge clk);
        i_addr    = v.i_addr;
        d_addr    = v.d_addr;
        d_wdata   = v.wdata;
        i_read    = (il > 0);
        d_write   = (dwl > 0);
        d_read    = (drl > 0);
        drive_cyc = cyc;
        while ((il > 0 || drl > 0 || dwl > 0) && budget < 400) begin
            @(negedge clk);
            budget++;
            if (i_ready) begin
                check_ready(1'b0, i_rdata);
                il--;
                ni++;
                i_addr = v.i_addr + 28'(ni);
            end
            if (d_ready) begin
                check_ready(1'b1, d_rdata);
                if (dwl > 0) dwl--;
                else         drl--;
            end
            i_read  = (il > 0);
            d_write = (dwl > 0);
            d_read  = (drl > 0);
        end
        if (budget >= 400) fail_now("vec_timeout");
        repeat (4) begin
            @(negedge clk);
            if (i_ready) check_ready(1'b0, i_rdata);
            if (d_ready) check_ready(1'b1, d_rdata);
        end
        chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
        chk("rdy_q_drained", 128'(rdy_q.size()), 128'(0));
        mem_q.delete();
        rdy_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_mem_read"}, 128'(mem_read), 128'(0));
        chk({tag, "_mem_write"}, 128'(mem_write), 128'(0));
        chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
        chk({tag, "_mem_wdata"}, mem_wdata, 128'(0));
        chk({tag, "_readies"}, 128'({i_ready, d_ready}), 128'(0));
        chk({tag, "_i_rdata"}, i_rdata, 128'(0));
        chk({tag, "_d_rdata"}, d_rdata, 128'(0));
    endtask

    vec_t vecs[7];

    initial begin
        int waited;
        vecs[0] = '{1, 0, 0, 28'h0000010, 28'h0000000, 128'h0, 5};
        vecs[1] = '{0, 1, 0, 28'h0000000, 28'h0000200, 128'h0, 3};
        vecs[2] = '{1, 1, 0, 28'h0000020, 28'h0000210, 128'h0, 4};
        vecs[3] = '{0, 1, 1, 28'h0000000, 28'h0000ABC, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 2};
        vecs[4] = '{0, 0, 1, 28'h0000000, 28'h0000440, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A, 1};
        vecs[5] = '{2, 2, 0, 28'h0000030, 28'h0000230, 128'h0, 2};
        vecs[6] = '{1, 1, 1, 28'h0000040, 28'h0000ABC, 128'h55555555_AAAAAAAA_33333333_CCCCCCCC, 1};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // mem_ready while idle must be ignored.
        @(negedge clk);
        #2 inject = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready_ignored", 128'({i_ready, d_ready}), 128'(0));
            chk("idle_no_strobe", 128'({mem_read, mem_write}), 128'(0));
        end
        chk("idle_i_rdata_kept", i_rdata, m_i_rdata);

        // Asynchronous reset in the middle of a D read.
        cur_lat = 10;
        mem_q.push_back('{1'b0, 28'h0000300, '0, 1'b1});
        @(negedge clk);
        d_addr    = 28'h0000300;
        d_read    = 1'b1;
        drive_cyc = cyc;
        waited    = 0;
        while (!mem_read && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!mem_read) fail_now("reset_txn_not_granted");
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        d_read = 1'b0;
        #1 check_all_zero("async_reset");
        m_last_d  = 1'b0;
        m_d_rdata = '0;
        m_i_rdata = '0;
        mem_q.delete();
        rdy_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(vecs[0]);
        chk("post_reset_d_rdata", d_rdata, 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
